// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: resolves branches, runs a req/ack data-memory access with timeout,
// stalls the pipeline while the access is in flight and registers the MEM/WB outputs.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemDataIn,
  input  logic [31:0] ReadData1In,
  input  logic [31:0] BranchAddResultIn,
  input  logic [4:0]  rdRegIn,
  input  logic        RegWriteIn,
  input  logic        MemWriteIn,
  input  logic        MemReadIn,
  input  logic        MemToRegIn,
  input  logic        ZeroIn,
  input  logic [1:0]  BranchIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic        BranchTakenOut,
  output logic [31:0] BranchTargetOut,
  output logic        MemErrOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] ReadDataOut,
  output logic [4:0]  rdRegOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          timed_out;

  logic mem_op;
  logic acc;
  logic misaligned;
  logic taken;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    mem_op     = MemReadIn | MemWriteIn;
    acc        = mem_op && (ALUResultIn[1:0] == 2'b00);
    misaligned = mem_op && !acc;

    taken = 1'b0;
    if (Reset_n && state == IDLE) begin
      case (BranchIn)
        2'b01:   taken = ZeroIn;
        2'b10:   taken = ~ZeroIn;
        2'b11:   taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end

    BranchTakenOut  = taken;
    BranchTargetOut = '0;
    if (taken) begin
      BranchTargetOut = (BranchIn == 2'b11) ? ReadData1In : BranchAddResultIn;
    end

    // Gated by reset so the pipeline is released the instant reset is asserted.
    Stall = Reset_n && ((state == IDLE && acc) || state == ACCESS);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: all registers here are plain flops (no memory arrays), so each one is reset.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata_q      <= '0;
      timed_out    <= 1'b0;
      MemReq       <= 1'b0;
      MemWe        <= 1'b0;
      MemAddr      <= '0;
      MemWData     <= '0;
      MemErrOut    <= 1'b0;
      ALUResultOut <= '0;
      ReadDataOut  <= '0;
      rdRegOut     <= '0;
      RegWriteOut  <= 1'b0;
      MemToRegOut  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            MemReq      <= 1'b1;
            MemWe       <= MemWriteIn & ~MemReadIn;
            MemAddr     <= ALUResultIn;
            MemWData    <= MemDataIn;
            cnt         <= '0;
            timed_out   <= 1'b0;
            RegWriteOut <= 1'b0;
            MemToRegOut <= 1'b0;
            state       <= ACCESS;
          end else begin
            ALUResultOut <= ALUResultIn;
            ReadDataOut  <= '0;
            rdRegOut     <= rdRegIn;
            RegWriteOut  <= RegWriteIn & ~misaligned;
            MemToRegOut  <= MemToRegIn;
            if (misaligned) begin
              MemErrOut <= 1'b1;
            end
          end
        end

        ACCESS: begin
          cnt <= cnt + CW'(1);
          // An ack on the expiry cycle is checked first, so it wins over the timeout.
          if (MemAck) begin
            MemReq  <= 1'b0;
            MemWe   <= 1'b0;
            rdata_q <= MemRData;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            rdata_q   <= '0;
            timed_out <= 1'b1;
            MemErrOut <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          ALUResultOut <= ALUResultIn;
          ReadDataOut  <= rdata_q;
          rdRegOut     <= rdRegIn;
          RegWriteOut  <= RegWriteIn & ~timed_out;
          MemToRegOut  <= MemToRegIn;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios then randomized instructions,
// each checked against a per-instruction transaction model.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic [31:0] ALUResultIn, MemDataIn, ReadData1In, BranchAddResultIn;
  logic [4:0]  rdRegIn;
  logic        RegWriteIn, MemWriteIn, MemReadIn, MemToRegIn, ZeroIn;
  logic [1:0]  BranchIn;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        Stall, BranchTakenOut;
  logic [31:0] BranchTargetOut;
  logic        MemErrOut;
  logic [31:0] ALUResultOut, ReadDataOut;
  logic [4:0]  rdRegOut;
  logic        RegWriteOut, MemToRegOut;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .Reset_n(Reset_n),
    .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn), .ReadData1In(ReadData1In),
    .BranchAddResultIn(BranchAddResultIn), .rdRegIn(rdRegIn),
    .RegWriteIn(RegWriteIn), .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
    .MemToRegIn(MemToRegIn), .ZeroIn(ZeroIn), .BranchIn(BranchIn),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData), .Stall(Stall),
    .BranchTakenOut(BranchTakenOut), .BranchTargetOut(BranchTargetOut),
    .MemErrOut(MemErrOut), .ALUResultOut(ALUResultOut), .ReadDataOut(ReadDataOut),
    .rdRegOut(rdRegOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive_nop();
    ALUResultIn = '0; MemDataIn = '0; ReadData1In = '0; BranchAddResultIn = '0;
    rdRegIn = '0; RegWriteIn = 0; MemWriteIn = 0; MemReadIn = 0; MemToRegIn = 0;
    ZeroIn = 0; BranchIn = 2'b00; MemAck = 0; MemRData = '0;
  endtask

  // Presents one instruction and follows it to retirement. ack_at: access cycle (1..TO) on
  // which memory acks; any larger value means memory never answers.
  task automatic run_instr(input logic [31:0] alu, input logic [31:0] wdata,
                           input logic [31:0] rs, input logic [31:0] tgt, input logic [4:0] rd,
                           input logic rw, input logic mw, input logic mr, input logic m2r,
                           input logic zero, input logic [1:0] br, input int ack_at,
                           input logic [31:0] rdata, input logic idle_ack);
    logic        is_mem, acc, mis, exp_we, exp_taken, timed;
    logic [31:0] exp_tgt, exp_rdata;
    logic        exp_rw;
    int          n_acc;

    @(negedge clk);
    ALUResultIn = alu; MemDataIn = wdata; ReadData1In = rs; BranchAddResultIn = tgt;
    rdRegIn = rd; RegWriteIn = rw; MemWriteIn = mw; MemReadIn = mr; MemToRegIn = m2r;
    ZeroIn = zero; BranchIn = br; MemAck = idle_ack; MemRData = rdata;

    is_mem    = mr | mw;
    acc       = is_mem && (alu % 4 == 0);
    mis       = is_mem && !acc;
    exp_we    = mw && !mr;
    exp_taken = (br == 2'd1 && zero) || (br == 2'd2 && !zero) || (br == 2'd3);
    exp_tgt   = !exp_taken ? 32'h0 : (br == 2'd3 ? rs : tgt);
    timed     = acc && (ack_at > TO);
    n_acc     = (ack_at > TO) ? TO : ack_at;

    #1;
    check("stall_first", Stall, acc);
    check("req_first", MemReq, 0);
    check("br_taken", BranchTakenOut, exp_taken);
    check("br_target", BranchTargetOut, exp_tgt);

    if (acc) begin
      for (int k = 1; k <= n_acc; k++) begin
        @(negedge clk);
        MemAck = (k == ack_at);
        #1;
        check("stall_acc", Stall, 1);
        check("req_acc", MemReq, 1);
        check("we_acc", MemWe, exp_we);
        check("addr_acc", MemAddr, alu);
        check("wdata_acc", MemWData, wdata);
        check("bubble_rw", RegWriteOut, 0);
        check("no_br_acc", BranchTakenOut, 0);
      end
      @(negedge clk);
      MemAck = idle_ack;
      #1;
      check("stall_done", Stall, 0);
      check("req_done", MemReq, 0);
      check("no_br_done", BranchTakenOut, 0);
    end

    @(posedge clk);
    #1;
    MemAck = 0;
    exp_rdata = (acc && !timed) ? rdata : 32'h0;
    exp_rw    = mis ? 1'b0 : (rw && !timed);
    if (mis || timed) exp_err = 1'b1;
    check("wb_alu", ALUResultOut, alu);
    check("wb_rdata", ReadDataOut, exp_rdata);
    check("wb_rd", rdRegOut, rd);
    check("wb_rw", RegWriteOut, exp_rw);
    check("wb_m2r", MemToRegOut, m2r);
    check("mem_err", MemErrOut, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, addr;
    int          kind;

    Reset_n = 1'b0;
    drive_nop();
    #1;
    check("rst_req", MemReq, 0);
    check("rst_stall", Stall, 0);
    check("rst_err", MemErrOut, 0);
    check("rst_rw", RegWriteOut, 0);
    check("rst_rdata", ReadDataOut, 0);
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;

    // lw 0x40, ack on 3rd access cycle: four stall cycles, load data retires with RegWrite
    run_instr(32'h40, 0, 0, 0, 5'd3, 1, 0, 1, 1, 0, 2'b00, 3, 32'hDEADBEEF, 0);
    // sw 0x44 with a stray ack in IDLE and DONE
    run_instr(32'h44, 32'h12345678, 0, 0, 5'd0, 0, 1, 0, 0, 0, 2'b00, 2, 32'h0BADF00D, 1);
    // non-memory op with a stray ack: must not stall or request
    run_instr(32'h55, 0, 0, 0, 5'd7, 1, 0, 0, 0, 0, 2'b00, 1, 32'h11111111, 1);
    // misaligned lw: no request, error set, no register write
    run_instr(32'h42, 0, 0, 0, 5'd4, 1, 0, 1, 1, 0, 2'b00, 1, 32'h22222222, 0);
    // lw that never gets an ack: timeout
    run_instr(32'h48, 0, 0, 0, 5'd6, 1, 0, 1, 1, 0, 2'b00, TO + 1, 32'h33333333, 0);
    // ack exactly on the expiry cycle wins
    run_instr(32'h4C, 0, 0, 0, 5'd8, 1, 0, 1, 1, 0, 2'b00, TO, 32'hCAFEF00D, 0);
    // both read and write set: read priority, MemWe=0
    run_instr(32'h50, 32'hAAAA5555, 0, 0, 5'd9, 1, 1, 1, 1, 0, 2'b00, 1, 32'h44444444, 0);
    // beq taken, bne not taken, jr taken
    run_instr(32'h0, 0, 32'h0, 32'h100, 5'd0, 0, 0, 0, 0, 1, 2'b01, 1, 0, 0);
    run_instr(32'h0, 0, 32'h0, 32'h180, 5'd0, 0, 0, 0, 0, 1, 2'b10, 1, 0, 0);
    run_instr(32'h0, 0, 32'h200, 32'h300, 5'd0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0);

    // Reset asserted mid-access
    @(negedge clk);
    ALUResultIn = 32'h60; MemReadIn = 1; RegWriteIn = 1; MemToRegIn = 1; rdRegIn = 5'd2;
    MemAck = 0;
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b0;
    #1;
    exp_err = 1'b0;
    check("midrst_req", MemReq, 0);
    check("midrst_stall", Stall, 0);
    check("midrst_we", MemWe, 0);
    check("midrst_addr", MemAddr, 0);
    check("midrst_err", MemErrOut, 0);
    check("midrst_alu", ALUResultOut, 0);
    check("midrst_rd", rdRegOut, 0);
    drive_nop();
    @(negedge clk);
    Reset_n = 1'b1;
    run_instr(32'h64, 0, 0, 0, 5'd10, 1, 0, 1, 1, 0, 2'b00, 2, 32'h87654321, 0);

    for (int i = 0; i < 200; i++) begin
      r    = $urandom;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: run_instr($urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                        0, 0, 1'($urandom), 1'($urandom), 2'b00, 1, $urandom, 1'($urandom));
        2, 3: run_instr($urandom, $urandom, $urandom, $urandom, 5'($urandom), 0,
                        0, 0, 0, 1'($urandom), 2'($urandom), 1, $urandom, 1'($urandom));
        4, 5: begin
          addr = r & 32'hFFFF_FFFC;
          run_instr(addr, $urandom, 0, 0, 5'($urandom), 1, 0, 1, 1, 0, 2'b00,
                    $urandom_range(1, TO + 1), $urandom, 1'($urandom));
        end
        6, 7: begin
          addr = r & 32'hFFFF_FFFC;
          run_instr(addr, $urandom, 0, 0, 5'($urandom), 0, 1, 0, 0, 0, 2'b00,
                    $urandom_range(1, TO + 1), $urandom, 1'($urandom));
        end
        8: begin
          addr = (r & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
          run_instr(addr, $urandom, 0, 0, 5'($urandom), 1, 1'($urandom), 1, 1, 0, 2'b00,
                    1, $urandom, 1'($urandom));
        end
        default: begin
          addr = r & 32'hFFFF_FFFC;
          run_instr(addr, $urandom, 0, 0, 5'($urandom), 1, 1, 1, 1, 0, 2'b00,
                    $urandom_range(1, TO + 1), $urandom, 0);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
